// File: rtl/spi_cmd_sequencer.sv
// Command FIFO and start/ready handshake sequencer in front of an SPI master.
// Commands with illegal bit counts are answered locally with an error response.
module spi_cmd_sequencer #(
  parameter int unsigned SPI_MAXLEN = 32,
  parameter int unsigned CMD_DEPTH  = 4,
  localparam int unsigned NW = $clog2(SPI_MAXLEN) + 1
) (
  input  logic                  clk,
  input  logic                  sresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [NW-1:0]         cmd_n_clks,
  input  logic [SPI_MAXLEN-1:0] cmd_tx_data,
  output logic                  start_cmd,
  input  logic                  spi_drv_rdy,
  output logic [NW-1:0]         n_clks,
  output logic [SPI_MAXLEN-1:0] tx_data,
  input  logic [SPI_MAXLEN-1:0] rx_miso,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SPI_MAXLEN-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

  state_e                state_q, state_d;
  logic                  start_q, start_d;
  logic [NW-1:0]         fifo_n [CMD_DEPTH];
  logic [SPI_MAXLEN-1:0] fifo_d [CMD_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [NW-1:0]         n_q;
  logic [SPI_MAXLEN-1:0] tx_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [SPI_MAXLEN-1:0] rsp_data_q;
  logic                  push, pop, load, rsp_set, rsp_set_err;
  logic [NW-1:0]         head_n;
  logic                  head_bad;

  assign cmd_ready = (count_q != CW'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head_n    = fifo_n[rd_ptr_q];
  assign head_bad  = (head_n == '0) || (head_n > NW'(SPI_MAXLEN));

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    pop         = 1'b0;
    load        = 1'b0;
    rsp_set     = 1'b0;
    rsp_set_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A pending response blocks issue so responses never overtake each other.
        if ((count_q != '0) && !rsp_valid_q) begin
          if (head_bad) begin
            pop         = 1'b1;
            rsp_set     = 1'b1;
            rsp_set_err = 1'b1;
          end else if (spi_drv_rdy) begin
            pop     = 1'b1;
            load    = 1'b1;
            start_d = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (!spi_drv_rdy) begin
          start_d = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (spi_drv_rdy) begin
          rsp_set = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q <= StIdle;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_n[wr_ptr_q] <= cmd_n_clks;
      fifo_d[wr_ptr_q] <= cmd_tx_data;
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      n_q         <= '0;
      tx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (load) begin
        n_q  <= head_n;
        tx_q <= fifo_d[rd_ptr_q];
      end
      if (rsp_set) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= rsp_set_err;
        rsp_data_q  <= rsp_set_err ? '0 : rx_miso;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign start_cmd = start_q;
  assign n_clks    = n_q;
  assign tx_data   = tx_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (count_q != '0) || (state_q != StIdle) || rsp_valid_q;

endmodule
